// File: rtl/oc8051_fetch_queue_pkg.sv
// Shared sizing constants and helpers for the instruction prefetch queue.
// Default queue depth, program address width and decoder consume width live here.
package oc8051_fetch_queue_pkg;

  localparam int FQ_DEPTH  = 8;
  localparam int FQ_ADDR_W = 16;
  localparam int FQ_CONS_W = 2;

  function automatic logic [FQ_CONS_W-1:0] fq_min2(input logic [FQ_CONS_W-1:0] a,
                                                   input logic [FQ_CONS_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/oc8051_fetch_queue_ram.sv
// Circular byte store: 3 bytes written at the tail per cycle, 3 bytes read combinationally at head.
// Write lands on posedge clk; read has zero latency; the pointer arithmetic wraps modulo QDEPTH.
module oc8051_fetch_queue_ram #(
  parameter int QDEPTH = 8,
  parameter int PW     = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] wptr_i,
  input  logic [7:0]    wdat1_i,
  input  logic [7:0]    wdat2_i,
  input  logic [7:0]    wdat3_i,
  input  logic [PW-1:0] rptr_i,
  output logic [7:0]    rdat1_o,
  output logic [7:0]    rdat2_o,
  output logic [7:0]    rdat3_o
);

  logic [7:0] mem_q [QDEPTH];

  // No reset: the top masks any byte beyond the valid count.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wptr_i]           <= wdat1_i;
      mem_q[wptr_i + PW'(1)]  <= wdat2_i;
      mem_q[wptr_i + PW'(2)]  <= wdat3_i;
    end
  end

  assign rdat1_o = mem_q[rptr_i];
  assign rdat2_o = mem_q[rptr_i + PW'(1)];
  assign rdat3_o = mem_q[rptr_i + PW'(2)];

endmodule

// File: rtl/oc8051_fetch_queue.sv
// Prefetch queue between program ROM and decoder: issues 3-byte reads, buffers them, exposes head bytes.
// First bytes visible two cycles after the fetch address appears; fetch stalls when the queue cannot absorb a return.
module oc8051_fetch_queue
  import oc8051_fetch_queue_pkg::*;
#(
  parameter int QDEPTH = FQ_DEPTH,
  parameter int ADDR_W = FQ_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [7:0]           rom_data1,
  input  logic [7:0]           rom_data2,
  input  logic [7:0]           rom_data3,
  input  logic                 rom_ea_int,
  input  logic                 jmp,
  input  logic [ADDR_W-1:0]    jmp_addr,
  input  logic [FQ_CONS_W-1:0] consume,
  output logic                 op_valid,
  output logic [1:0]           op_cnt,
  output logic [7:0]           op1,
  output logic [7:0]           op2,
  output logic [7:0]           op3,
  output logic [ADDR_W-1:0]    op_pc,
  output logic                 ext_miss
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fpc_q, fpc_d, op_pc_q, op_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic              inflight_q, inflight_d, kill_q, kill_d, ext_miss_q, ext_miss_d;

  logic [1:0]  cnt_sat, pop;
  logic [CW:0] occ;
  logic        issue, ret_ok, push, miss;
  logic [7:0]  rd1, rd2, rd3;

  assign cnt_sat = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
  assign pop     = jmp ? 2'd0 : fq_min2(consume, cnt_sat);

  // Budget the pending return as if it were already queued, so a new issue can never overflow.
  assign occ    = {1'b0, count_q} + (inflight_q ? (CW+1)'(3) : '0);
  assign issue  = !ext_miss_q && !jmp && (occ <= (CW+1)'(QDEPTH - 3));
  assign ret_ok = inflight_q && !kill_q && !ext_miss_q && !jmp;
  assign push   = ret_ok && rom_ea_int;
  assign miss   = ret_ok && !rom_ea_int;

  always_comb begin
    fpc_d      = issue ? fpc_q + ADDR_W'(3) : fpc_q;
    inflight_d = issue;
    kill_d     = jmp && inflight_q;
    ext_miss_d = ext_miss_q || miss;
    tail_d     = push ? tail_q + PW'(3) : tail_q;
    head_d     = head_q + PW'(pop);
    count_d    = count_q + (push ? CW'(3) : '0) - CW'(pop);
    op_pc_d    = op_pc_q + ADDR_W'(pop);
    if (jmp) begin
      fpc_d      = jmp_addr;
      ext_miss_d = 1'b0;
      head_d     = tail_q;
      count_d    = '0;
      op_pc_d    = jmp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_q      <= '0;
      op_pc_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      ext_miss_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      op_pc_q    <= op_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      ext_miss_q <= ext_miss_d;
    end
  end

  oc8051_fetch_queue_ram #(.QDEPTH(QDEPTH), .PW(PW)) u_ram (
    .clk     (clk),
    .we_i    (push && rst),
    .wptr_i  (tail_q),
    .wdat1_i (rom_data1),
    .wdat2_i (rom_data2),
    .wdat3_i (rom_data3),
    .rptr_i  (head_q),
    .rdat1_o (rd1),
    .rdat2_o (rd2),
    .rdat3_o (rd3)
  );

  assign rom_addr = fpc_q;
  assign op_valid = (count_q != '0);
  assign op_cnt   = cnt_sat;
  assign op1      = (cnt_sat >= 2'd1) ? rd1 : 8'h00;
  assign op2      = (cnt_sat >= 2'd2) ? rd2 : 8'h00;
  assign op3      = (cnt_sat == 2'd3) ? rd3 : 8'h00;
  assign op_pc    = op_pc_q;
  assign ext_miss = ext_miss_q;

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Directed bench for the prefetch queue with a registered 3-byte ROM model.
module tb_oc8051_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data1 = 8'h00, rom_data2 = 8'h00, rom_data3 = 8'h00;
  logic        rom_ea_int = 1'b0;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic [1:0]  consume;
  logic        op_valid;
  logic [1:0]  op_cnt;
  logic [7:0]  op1, op2, op3;
  logic [15:0] op_pc;
  logic        ext_miss;

  logic [7:0]  mem [0:65535];
  logic        lim7;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_pc;

  oc8051_fetch_queue dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr),
    .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3),
    .rom_ea_int(rom_ea_int), .jmp(jmp), .jmp_addr(jmp_addr), .consume(consume),
    .op_valid(op_valid), .op_cnt(op_cnt), .op1(op1), .op2(op2), .op3(op3),
    .op_pc(op_pc), .ext_miss(ext_miss)
  );

  always #5 clk = ~clk;

  // Registered ROM; optional 7-bit internal space (addresses >= 0080 are external).
  always @(posedge clk) begin
    rom_data1  <= mem[rom_addr];
    rom_data2  <= mem[rom_addr + 16'd1];
    rom_data3  <= mem[rom_addr + 16'd2];
    rom_ea_int <= !lim7 || (rom_addr < 16'h0080);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h19;
    mem[16'h0003] = 8'h7F; mem[16'h0004] = 8'h40; mem[16'h0005] = 8'h7E;
    mem[16'h0019] = 8'h78; mem[16'h001A] = 8'h7F;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;

    rst = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000; consume = 2'd0; lim7 = 1'b0;
    tick(2);
    chk("rst_addr",  rom_addr, 16'h0000);
    chk("rst_vld",   op_valid, 1'b0);
    chk("rst_cnt",   op_cnt,   2'd0);
    chk("rst_op1",   op1,      8'h00);
    chk("rst_pc",    op_pc,    16'h0000);
    chk("rst_miss",  ext_miss, 1'b0);

    // Reset release: C0 issues 0000, C1 writes, C2 presents.
    rst = 1'b1;
    tick(2);
    chk("c2_vld",  op_valid, 1'b1);
    chk("c2_cnt",  op_cnt,   2'd3);
    chk("c2_op1",  op1,      8'h02);
    chk("c2_op2",  op2,      8'h00);
    chk("c2_op3",  op3,      8'h19);
    chk("c2_pc",   op_pc,    16'h0000);
    chk("c2_addr", rom_addr, 16'h0006);

    consume = 2'd3;
    tick(1);
    chk("pop3_pc",  op_pc, 16'h0003);
    chk("pop3_op1", op1,   8'h7F);
    chk("pop3_op2", op2,   8'h40);
    chk("pop3_op3", op3,   8'h7E);
    consume = 2'd2;
    tick(1);
    consume = 2'd0;
    chk("pop2_pc",  op_pc, 16'h0005);
    chk("pop2_op1", op1,   8'h7E);

    // Stall: queue holds 0005..000B, fetch parked at 000C.
    tick(20);
    chk("stall_addr", rom_addr, 16'h000C);
    chk("stall_cnt",  op_cnt,   2'd3);
    chk("stall_pc",   op_pc,    16'h0005);

    exp_pc = 16'h0005;
    for (int k = 0; k < 12; k++) begin
      chk("drain_vld", op_valid, 1'b1);
      chk("drain_pc",  op_pc,    exp_pc);
      chk("drain_op1", op1,      mem[exp_pc]);
      consume = 2'd1;
      tick(1);
      exp_pc = exp_pc + 16'd1;
    end
    consume = 2'd0;

    // Jump while a return is in flight; the stale bytes from 0000 must not appear.
    jmp_addr = 16'h0000; jmp = 1'b1;
    tick(1);
    jmp = 1'b0;
    tick(1);
    jmp_addr = 16'h0019; jmp = 1'b1;
    tick(1);
    jmp = 1'b0;
    chk("jmp_flush", op_valid, 1'b0);
    chk("jmp_addr",  rom_addr, 16'h0019);
    consume = 2'd3;
    tick(1);
    chk("jmp_empty", op_valid, 1'b0);
    tick(1);
    consume = 2'd0;
    chk("jmp_vld", op_valid, 1'b1);
    chk("jmp_cnt", op_cnt,   2'd3);
    chk("jmp_op1", op1,      8'h78);
    chk("jmp_op2", op2,      8'h7F);
    chk("jmp_pc",  op_pc,    16'h0019);

    // External fetch with a 7-bit internal ROM.
    lim7 = 1'b1;
    jmp_addr = 16'h0080; jmp = 1'b1;
    tick(1);
    jmp = 1'b0;
    tick(2);
    chk("ext_miss", ext_miss, 1'b1);
    chk("ext_vld",  op_valid, 1'b0);
    tick(3);
    chk("ext_hold", rom_addr, 16'h0086);
    chk("ext_vld2", op_valid, 1'b0);
    chk("ext_stky", ext_miss, 1'b1);
    jmp_addr = 16'h0000; jmp = 1'b1;
    tick(1);
    jmp = 1'b0;
    chk("miss_clr",  ext_miss, 1'b0);
    chk("miss_addr", rom_addr, 16'h0000);
    tick(2);
    chk("miss_vld", op_valid, 1'b1);
    chk("miss_op1", op1,      8'h02);
    lim7 = 1'b0;

    // Address wrap.
    jmp_addr = 16'hFFFE; jmp = 1'b1;
    tick(1);
    jmp = 1'b0;
    tick(2);
    chk("wrap_pc",  op_pc, 16'hFFFE);
    chk("wrap_op1", op1,   8'hAA);
    chk("wrap_op2", op2,   8'hBB);
    chk("wrap_op3", op3,   8'h02);
    consume = 2'd2;
    tick(1);
    consume = 2'd0;
    chk("wrap_pc2",  op_pc, 16'h0000);
    chk("wrap2_op1", op1,   8'h02);
    chk("wrap2_op2", op2,   8'h00);

    // Reset in the middle of a fill.
    rst = 1'b0;
    tick(1);
    chk("mrst_addr", rom_addr, 16'h0000);
    chk("mrst_vld",  op_valid, 1'b0);
    chk("mrst_cnt",  op_cnt,   2'd0);
    chk("mrst_op1",  op1,      8'h00);
    chk("mrst_op2",  op2,      8'h00);
    chk("mrst_op3",  op3,      8'h00);
    chk("mrst_pc",   op_pc,    16'h0000);
    chk("mrst_miss", ext_miss, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("rerst_vld", op_valid, 1'b1);
    chk("rerst_op1", op1,      8'h02);
    chk("rerst_pc",  op_pc,    16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
